// File: rtl/cell_paint_arbiter.sv
// Round-robin arbiter between maze loader and solver; expands one granted cell
// into CELL_PX x CELL_PX frame-buffer writes. Optional macro: CELL_BORDER_EN.
module cell_paint_arbiter #(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 12,
  parameter int COORD_W = 4,
  parameter int CELL_PX = 8,
  parameter int COLOR_W = 8,
  parameter int ADDR_W  = 14,
  parameter logic [COLOR_W-1:0] BORDER_COLOR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m_valid,
  output logic               m_ready,
  input  logic [COORD_W-1:0] m_x,
  input  logic [COORD_W-1:0] m_y,
  input  logic [COLOR_W-1:0] m_color,
  output logic               m_done,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [COORD_W-1:0] s_x,
  input  logic [COORD_W-1:0] s_y,
  input  logic [COLOR_W-1:0] s_color,
  output logic               s_done,
  output logic               fb_we,
  input  logic               fb_ready,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               busy,
  output logic               err
);
  localparam int PW     = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int ROW_PX = GRID_W * CELL_PX;
  localparam logic [PW-1:0] LAST = PW'(CELL_PX - 1);
`ifdef CELL_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PAINT, DONE} state_t;
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
    logic               id;   // 1 = solver
  } req_t;

  state_t        state;
  req_t          req, in_req;
  logic          last_grant;  // 1 = solver served last
  logic [PW-1:0] px, py, nxt_px, nxt_py;
  logic          acc_m, acc_s, acc, in_range, on_edge;
  logic [COORD_W-1:0] tgt_x, tgt_y;
  logic [COLOR_W-1:0] tgt_color, nxt_data;
  logic [ADDR_W-1:0]  nxt_addr;
  logic [31:0]        full_addr;

  // {s_ready, m_ready}; with nobody asking, offer to whoever was not served last
  function automatic logic [1:0] pick(input logic mv, input logic sv, input logic lg);
    if (mv && sv) return lg ? 2'b01 : 2'b10;
    if (mv)       return 2'b01;
    if (sv)       return 2'b10;
    return lg ? 2'b01 : 2'b10;
  endfunction

  always_comb begin
    acc_m     = m_valid & m_ready;
    acc_s     = s_valid & s_ready;
    acc       = acc_m | acc_s;
    in_req.x     = acc_s ? s_x : m_x;
    in_req.y     = acc_s ? s_y : m_y;
    in_req.color = acc_s ? s_color : m_color;
    in_req.id    = acc_s;
    in_range  = (int'(in_req.x) < GRID_W) && (int'(in_req.y) < GRID_H);
    // In IDLE the first pixel is formed straight from the incoming request
    tgt_x     = (state == IDLE) ? in_req.x     : req.x;
    tgt_y     = (state == IDLE) ? in_req.y     : req.y;
    tgt_color = (state == IDLE) ? in_req.color : req.color;
    nxt_px    = (state == IDLE) ? '0 : px + 1'b1;
    nxt_py    = (state == IDLE) ? '0 : py + PW'(px == LAST);
    full_addr = (32'(tgt_y) * CELL_PX + 32'(nxt_py)) * ROW_PX
              + 32'(tgt_x) * CELL_PX + 32'(nxt_px);
    nxt_addr  = full_addr[ADDR_W-1:0];
    on_edge   = (nxt_px == '0) || (nxt_px == LAST) || (nxt_py == '0) || (nxt_py == LAST);
    nxt_data  = (BORDER_EN && on_edge) ? BORDER_COLOR : tgt_color;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req        <= '0;
      last_grant <= 1'b1;
      px         <= '0;
      py         <= '0;
      m_ready    <= 1'b0;
      s_ready    <= 1'b0;
      m_done     <= 1'b0;
      s_done     <= 1'b0;
      err        <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
    end else begin
      m_done <= 1'b0;
      s_done <= 1'b0;
      err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc) begin
            req        <= in_req;
            last_grant <= acc_s;
            m_ready    <= 1'b0;
            s_ready    <= 1'b0;
            px         <= '0;
            py         <= '0;
            if (in_range) begin
              state   <= PAINT;
              fb_we   <= 1'b1;
              fb_addr <= nxt_addr;
              fb_data <= nxt_data;
            end else begin
              state  <= DONE;
              m_done <= ~acc_s;
              s_done <= acc_s;
              err    <= 1'b1;
            end
          end else begin
            {s_ready, m_ready} <= pick(m_valid, s_valid, last_grant);
          end
        end
        PAINT: begin
          if (fb_ready) begin
            if (px == LAST && py == LAST) begin
              state  <= DONE;
              fb_we  <= 1'b0;
              m_done <= ~req.id;
              s_done <= req.id;
            end else begin
              px      <= nxt_px;
              py      <= nxt_py;
              fb_addr <= nxt_addr;
              fb_data <= nxt_data;
            end
          end
        end
        DONE: begin
          state              <= IDLE;
          {s_ready, m_ready} <= pick(m_valid, s_valid, last_grant);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/cell_paint_arbiter.md
# cell_paint_arbiter

Shares the frame-buffer write port between the maze loader and the solver. Each requester asks for one grid cell to be painted a colour. The block arbitrates round-robin, expands the granted cell into CELL_PX×CELL_PX pixel writes, and signals completion. It sits between the cell-level logic (maze load, solver step) and the pixel-level frame buffer that the VGA scan reads.

## Interface
- GRID_W, 16: grid width in cells
- GRID_H, 12: grid height in cells
- COORD_W, 4: cell coordinate width
- CELL_PX, 8: cell edge in pixels (power of two)
- COLOR_W, 8: pixel colour width
- ADDR_W, 14: frame-buffer address width; must hold GRID_W·GRID_H·CELL_PX²
- BORDER_COLOR, 8'h00: border colour, used only with CELL_BORDER_EN
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- m_valid  in  1  maze request valid
- m_ready  out  1  maze request accepted when m_valid & m_ready
- m_x, m_y  in  COORD_W  maze cell coordinates
- m_color  in  COLOR_W  maze cell colour
- m_done  out  1  one-cycle pulse when the maze cell is finished
- s_valid, s_ready, s_x, s_y, s_color, s_done: same roles for the solver
- fb_we  out  1  pixel write valid
- fb_ready  in  1  frame buffer accepts the write when fb_we & fb_ready
- fb_addr  out  ADDR_W  linear pixel address
- fb_data  out  COLOR_W  pixel colour
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse when an accepted request is out of range

## Operation
- **FSM states:** IDLE, PAINT, DONE.
- **IDLE:**
  - At most one ready is high.
  - If both requesters are valid, grant the one not served last.
  - If one is valid, grant it.
  - The grant is registered into last_grant.
  - On accept, latch x, y, colour and requester ID, then go to PAINT with px=py=0.
- **Range check:** if x≥GRID_W or y≥GRID_H, go straight to DONE. Issue no writes and pulse err together with the done pulse.
- **PAINT:**
  - fb_we=1.
  - fb_addr = (y·CELL_PX + py)·(GRID_W·CELL_PX) + x·CELL_PX + px, computed at full width and truncated to ADDR_W.
  - fb_data = latched colour.
  - On each fb_we & fb_ready: px increments. When px wraps from CELL_PX−1 to 0, py increments.
  - The beat at px=py=CELL_PX−1 moves the FSM to DONE.
- **DONE:** one cycle. Pulse m_done or s_done (whichever requester was served), then return to IDLE.
- **Backpressure:** while fb_we=1 and fb_ready=0, fb_addr, fb_data and the counters hold.
- **Requester inputs:** a requester's valid may drop without being accepted. Its inputs are sampled only on accept.

## Timing
- **Reset values:** m_ready=s_ready=0, fb_we=0, fb_addr=0, fb_data=0, m_done=s_done=0, err=0, busy=0. FSM=IDLE, last_grant=solver (so the maze wins the first tie).
- **Ready outputs:** registered, asserted in IDLE. Earliest ready is the first cycle after reset release.
- **Valid cell, accept at cycle T, no stalls:**
  - fb_we is high T+1 through T+CELL_PX².
  - done pulses at T+CELL_PX²+1.
  - Ready can rise again at T+CELL_PX²+2.
- **Out-of-range cell:** accept at T, done and err at T+1.
- **Stalls:** each fb_ready=0 cycle during PAINT delays done by one cycle.
- **Simultaneous valids:** arbitration resolves in the same cycle. Only one requester is accepted per IDLE visit.
- **Reset mid-PAINT:** the write stops immediately and all outputs return to reset values. No done is issued. The cell is partially painted and the requester must re-issue.

## Configuration
- **CELL_BORDER_EN defined:** pixels with px∈{0,CELL_PX−1} or py∈{0,CELL_PX−1} are written with BORDER_COLOR. Interior pixels use the request colour.
- **CELL_BORDER_EN undefined:** every pixel uses the request colour and BORDER_COLOR is ignored.
- Write count and timing are identical in both builds.

## Test plan
- **Single maze request:** maze request (x=2, y=3, colour 8'hE0), fb_ready=1.
  - Required: 64 writes, first address 3·8·128+16=3088, last address 3088+7·128+7=3991, all data E0.
  - Required: m_done at accept+65; s_done stays 0.
- **Simultaneous requests:** m_valid=s_valid=1 at reset release → maze served first, solver second. Repeat with both valid → grants alternate maze, solver, maze.
- **Backpressure:** toggle fb_ready 1,0,1,0… during PAINT → 64 unique addresses in order, address and data stable across each stall, done at accept+129.
- **Out of range:** solver request x=16 → no fb_we; s_done and err both pulse at accept+1.
- **Reset mid-PAINT:** assert rst_n=0 after the 20th write → all outputs 0 while reset is held. After release, a new request paints from px=py=0.
- **CELL_BORDER_EN build:** BORDER_COLOR=8'h00, colour 8'hFF → 28 writes of 00 on the cell edges, 36 writes of FF in the interior.
